// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Latency: request accepted in N, issued from N+1, response routed combinationally with mem_rsp_valid_i.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_kill_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_req_valid_i,
    output logic            ls_req_ready_o,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [3:0]      ls_wstrb_i,
    output logic            ls_rsp_valid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_wstrb_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic       OWN_LS   = 1'b0;
    localparam logic       OWN_IF   = 1'b1;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    logic [1:0]      state;
    logic            owner;
    logic            drop;
    logic [3:0]      starve_cnt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic [3:0]      wstrb_q;

    logic in_idle;
    logic grant_if;
    logic grant_ls;
    logic rsp_hit;

    // Grants are suppressed while reset is asserted so no handshake is lost to reset.
    always_comb begin
        in_idle  = (state == ST_IDLE) && !rst_i;
        grant_if = in_idle && if_req_valid_i && (!ls_req_valid_i || starve_cnt == LIMIT);
        grant_ls = in_idle && ls_req_valid_i && !grant_if;
        rsp_hit  = (state == ST_WAIT) && mem_rsp_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            owner      <= OWN_LS;
            drop       <= 1'b0;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wstrb_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        addr_q     <= if_addr_i;
                        wdata_q    <= '0;
                        we_q       <= 1'b0;
                        wstrb_q    <= '0;
                        owner      <= OWN_IF;
                        drop       <= 1'b0;
                        starve_cnt <= '0;
                        state      <= ST_ISSUE;
                    end else if (grant_ls) begin
                        addr_q  <= ls_addr_i;
                        wdata_q <= ls_wdata_i;
                        we_q    <= ls_we_i;
                        wstrb_q <= ls_wstrb_i;
                        owner   <= OWN_LS;
                        drop    <= 1'b0;
                        if (if_req_valid_i && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (owner == OWN_IF && if_kill_i)
                        drop <= 1'b1;
                    if (mem_req_ready_i)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (owner == OWN_IF && if_kill_i)
                        drop <= 1'b1;
                    if (mem_rsp_valid_i)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A kill arriving in the response cycle itself must also swallow the fetch data.
    always_comb begin
        if_req_ready_o  = grant_if;
        ls_req_ready_o  = grant_ls;
        mem_req_valid_o = (state == ST_ISSUE);
        mem_addr_o      = addr_q;
        mem_wdata_o     = wdata_q;
        mem_we_o        = we_q;
        mem_wstrb_o     = wstrb_q;
        if_rsp_valid_o  = rsp_hit && (owner == OWN_IF) && !drop && !if_kill_i;
        ls_rsp_valid_o  = rsp_hit && (owner == OWN_LS);
        if_rdata_o      = if_rsp_valid_o ? mem_rdata_i : '0;
        ls_rdata_o      = (ls_rsp_valid_o && !we_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, routing, priority/starvation, kill, mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_valid_i = 1'b0;
    logic        if_req_ready_o;
    logic [31:0] if_addr_i = '0;
    logic        if_kill_i = 1'b0;
    logic        if_rsp_valid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_valid_i = 1'b0;
    logic        ls_req_ready_o;
    logic [31:0] ls_addr_i = '0;
    logic        ls_we_i = 1'b0;
    logic [31:0] ls_wdata_i = '0;
    logic [3:0]  ls_wstrb_i = '0;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int ls_idx   = 0;

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
        .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rdata_o(if_rdata_o),
        .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o),
        .ls_addr_i(ls_addr_i), .ls_we_i(ls_we_i), .ls_wdata_i(ls_wdata_i),
        .ls_wstrb_i(ls_wstrb_i), .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; one-cycle memory pulses default low.
    task automatic step();
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        if_kill_i       = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mreq"}, {31'd0, mem_req_valid_o}, 32'd0);
        chk({tag, "_ifrsp"}, {31'd0, if_rsp_valid_o}, 32'd0);
        chk({tag, "_lsrsp"}, {31'd0, ls_rsp_valid_o}, 32'd0);
        chk({tag, "_ifrd"}, if_rdata_o, 32'd0);
        chk({tag, "_lsrd"}, ls_rdata_o, 32'd0);
    endtask

    // Full 3-cycle transaction with both requesters valid; exp_if selects the expected winner.
    task automatic both_txn(input logic exp_if, input logic [31:0] rd);
        logic        we;
        logic [31:0] la;
        step();
        we             = (ls_idx % 2 == 0);
        la             = 32'h1000 + 32'(ls_idx) * 4;
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'h40;
        ls_req_valid_i = 1'b1;
        ls_addr_i      = la;
        ls_we_i        = we;
        ls_wdata_i     = 32'hD000 + 32'(ls_idx);
        ls_wstrb_i     = we ? 4'hF : 4'h0;
        #1;
        chk("arb_if_rdy", {31'd0, if_req_ready_o}, {31'd0, exp_if});
        chk("arb_ls_rdy", {31'd0, ls_req_ready_o}, {31'd0, !exp_if});
        step();
        mem_req_ready_i = 1'b1;
        #1;
        chk("arb_busy_rdy", {30'd0, if_req_ready_o, ls_req_ready_o}, 32'd0);
        chk("arb_mreq", {31'd0, mem_req_valid_o}, 32'd1);
        chk("arb_addr", mem_addr_o, exp_if ? 32'h40 : la);
        chk("arb_we", {31'd0, mem_we_o}, {31'd0, !exp_if && we});
        chk("arb_wstrb", {28'd0, mem_wstrb_o}, (!exp_if && we) ? 32'hF : 32'h0);
        chk("arb_wdata", mem_wdata_o, exp_if ? 32'h0 : 32'hD000 + 32'(ls_idx));
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = rd;
        #1;
        chk("arb_ifrsp", {31'd0, if_rsp_valid_o}, {31'd0, exp_if});
        chk("arb_lsrsp", {31'd0, ls_rsp_valid_o}, {31'd0, !exp_if});
        chk("arb_ifrd", if_rdata_o, exp_if ? rd : 32'h0);
        chk("arb_lsrd", ls_rdata_o, (!exp_if && !we) ? rd : 32'h0);
        if (!exp_if) ls_idx++;
    endtask

    initial begin
        logic [9:0] order;
        order = 10'b10_0001_0000;

        // Reset, then quiet idle.
        step();
        step();
        rst_i = 1'b0;
        step();
        #1;
        check_quiet("rst");
        chk("rst_rdy", {30'd0, if_req_ready_o, ls_req_ready_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);

        // Single fetch, best-case timing.
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'h10;
        #1;
        chk("t1_ifrdy", {31'd0, if_req_ready_o}, 32'd1);
        step();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        chk("t1_mreq", {31'd0, mem_req_valid_o}, 32'd1);
        chk("t1_addr", mem_addr_o, 32'h10);
        chk("t1_we", {31'd0, mem_we_o}, 32'd0);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h00500093;
        #1;
        chk("t1_ifrsp", {31'd0, if_rsp_valid_o}, 32'd1);
        chk("t1_ifrd", if_rdata_o, 32'h00500093);
        chk("t1_lsrsp", {31'd0, ls_rsp_valid_o}, 32'd0);
        step();
        #1;
        check_quiet("t1_after");

        // Continuous contention: LS x4, IF, LS x4, IF.
        for (int g = 0; g < 10; g++) begin
            logic [9:0] ord;
            ord = order;
            both_txn(ord[g], 32'hA5A50000 + 32'(g));
        end

        // Stalled fetch killed during ISSUE.
        step();
        ls_req_valid_i = 1'b0;
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'h200;
        #1;
        chk("t3_ifrdy", {31'd0, if_req_ready_o}, 32'd1);
        step();
        if_req_valid_i = 1'b0;
        if_addr_i      = 32'hDEAD;
        if_kill_i      = 1'b1;
        #1;
        chk("t3_mreq0", {31'd0, mem_req_valid_o}, 32'd1);
        chk("t3_addr0", mem_addr_o, 32'h200);
        for (int s = 1; s < 4; s++) begin
            step();
            mem_req_ready_i = (s == 3);
            #1;
            chk("t3_mreq", {31'd0, mem_req_valid_o}, 32'd1);
            chk("t3_addr", mem_addr_o, 32'h200);
        end
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h1234;
        #1;
        chk("t3_ifrsp", {31'd0, if_rsp_valid_o}, 32'd0);
        chk("t3_ifrd", if_rdata_o, 32'd0);
        step();
        #1;
        check_quiet("t3_after");

        // Kill in the response cycle: fetch suppressed, then LS unaffected.
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'h80;
        #1;
        chk("t4_ifrdy", {31'd0, if_req_ready_o}, 32'd1);
        step();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h55;
        if_kill_i       = 1'b1;
        #1;
        chk("t4_ifrsp", {31'd0, if_rsp_valid_o}, 32'd0);
        chk("t4_ifrd", if_rdata_o, 32'd0);
        step();
        ls_req_valid_i = 1'b1;
        ls_addr_i      = 32'h300;
        ls_we_i        = 1'b0;
        ls_wstrb_i     = 4'h0;
        #1;
        chk("t4_idle_lsrdy", {31'd0, ls_req_ready_o}, 32'd1);
        step();
        ls_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hCAFEF00D;
        if_kill_i       = 1'b1;
        #1;
        chk("t4_lsrsp", {31'd0, ls_rsp_valid_o}, 32'd1);
        chk("t4_lsrd", ls_rdata_o, 32'hCAFEF00D);
        chk("t4_ifrsp2", {31'd0, if_rsp_valid_o}, 32'd0);

        // Reset while waiting; late response must be dropped.
        step();
        ls_req_valid_i = 1'b1;
        ls_addr_i      = 32'h400;
        #1;
        chk("t5_lsrdy", {31'd0, ls_req_ready_o}, 32'd1);
        step();
        ls_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check_quiet("t5_rst");
        chk("t5_addr", mem_addr_o, 32'd0);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h77;
        #1;
        check_quiet("t5_late");
        both_txn(1'b0, 32'h88);

        // Spurious response in idle; starvation count (now 1) must survive it.
        step();
        if_req_valid_i  = 1'b0;
        ls_req_valid_i  = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h99;
        #1;
        check_quiet("t6_spur");
        chk("t6_rdy", {30'd0, if_req_ready_o, ls_req_ready_o}, 32'd0);
        both_txn(1'b0, 32'h101);
        both_txn(1'b0, 32'h102);
        both_txn(1'b0, 32'h103);
        both_txn(1'b1, 32'h104);
        step();
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
